// File: rtl/p_acc_seq_pkg.sv
// ----------------------------------------------------------------------------
// p_acc_seq_pkg
// Shared types and constants for the sequenced partial accumulator.
//   dtype_t / dconf_t : data configuration (integer or fixed-point, word width)
//   DEF_DCONF_C       : default configuration, 8-bit integer
//   S_IDLE/S_ACC/S_OUT: sequencer FSM state encodings
//   cnt_width()       : beat counter width, never below one bit
// The `DEF_DCONF macro expands to the default configuration so that modules
// can use it as a parameter default.
// ----------------------------------------------------------------------------
package p_acc_seq_pkg;

    typedef enum logic [0:0] {
        DT_INT = 1'b0,
        DT_FXP = 1'b1
    } dtype_t;

    typedef struct packed {
        dtype_t     dtype;
        logic [7:0] prec;
    } dconf_t;

    localparam dconf_t DEF_DCONF_C = '{dtype: DT_INT, prec: 8'd8};

    typedef logic [1:0] acc_seq_state_t;

    localparam acc_seq_state_t S_IDLE = 2'd0;
    localparam acc_seq_state_t S_ACC  = 2'd1;
    localparam acc_seq_state_t S_OUT  = 2'd2;

    function automatic int cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

`ifndef DEF_DCONF
`define DEF_DCONF p_acc_seq_pkg::DEF_DCONF_C
`endif

// File: rtl/p_acc_seq_p_acc.sv
// ----------------------------------------------------------------------------
// p_acc
// Combinational saturating adder tree: sums IN signed words of CONF.prec bits
// and clips the exact result to the word range.
// Ports:
//   in_data  in  IN x prec  operand lanes
//   out_data out prec       saturated sum
//   out_ovf  out 1          INT: clipped either way; FXP: clipped at the top
//   out_udf  out 1          FXP: clipped at the bottom; INT: 0
//   out_rnd  out 1          always 0 (equal-format addition is exact)
// ----------------------------------------------------------------------------
module p_acc
    import p_acc_seq_pkg::*;
#(
    parameter int     IN   = 9,
    parameter dconf_t CONF = `DEF_DCONF
) (
    input  logic [IN-1:0][CONF.prec-1:0] in_data,
    output logic [CONF.prec-1:0]         out_data,
    output logic                         out_ovf,
    output logic                         out_udf,
    output logic                         out_rnd
);

    localparam int W  = int'(CONF.prec);
    // Headroom for IN lanes plus one guard bit: the wide sum can never wrap.
    localparam int SW = W + $clog2(IN) + 1;

    localparam logic signed [SW-1:0] MAX_C = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_C = {{(SW-W+1){1'b1}}, {(W-1){1'b0}}};

    logic signed [SW-1:0] w_sum;
    logic                 w_pos_sat;
    logic                 w_neg_sat;

    // Exact wide sum of all sign-extended lanes.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < IN; i++) begin
            w_sum = w_sum + {{(SW-W){in_data[i][W-1]}}, in_data[i]};
        end
    end

    // Clip the wide sum into the word range and note which side clipped.
    always_comb begin
        w_pos_sat = 1'b0;
        w_neg_sat = 1'b0;
        out_data  = w_sum[W-1:0];
        if (w_sum > MAX_C) begin
            w_pos_sat = 1'b1;
            out_data  = MAX_C[W-1:0];
        end else if (w_sum < MIN_C) begin
            w_neg_sat = 1'b1;
            out_data  = MIN_C[W-1:0];
        end else begin
            out_data  = w_sum[W-1:0];
        end
    end

    // Map clipping onto status flags according to the data type.
    always_comb begin
        out_rnd = 1'b0;
        if (CONF.dtype == DT_FXP) begin
            out_ovf = w_pos_sat;
            out_udf = w_neg_sat;
        end else begin
            out_ovf = w_pos_sat | w_neg_sat;
            out_udf = 1'b0;
        end
    end

endmodule

// File: rtl/p_acc_seq.sv
// ----------------------------------------------------------------------------
// p_acc_seq
// Folds BEATS chunks of IN products into one neuron sum by time-multiplexing a
// single (IN+1)-input p_acc; the running sum is fed back on lane IN.
// Ports:
//   clk, reset_             clock, async active-low reset
//   in_valid/in_ready       chunk handshake
//   in_data   IN x prec     chunk of products
//   out_valid/out_ready     result handshake, result held until taken
//   out_data  prec          accumulated sum
//   out_ovf/out_udf/out_rnd sticky status over all beats of the vector
//   bias      prec          first-beat feedback value (P_ACC_SEQ_BIAS_EN only)
// Build option: define P_ACC_SEQ_BIAS_EN to add the bias port; otherwise the
// first beat of every vector starts from zero.
// ----------------------------------------------------------------------------
module p_acc_seq
    import p_acc_seq_pkg::*;
#(
    parameter int     IN    = 8,
    parameter int     BEATS = 4,
    parameter dconf_t CONF  = `DEF_DCONF
) (
    input  logic                         clk,
    input  logic                         reset_,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IN-1:0][CONF.prec-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CONF.prec-1:0]         out_data,
    output logic                         out_ovf,
    output logic                         out_udf,
    output logic                         out_rnd
`ifdef P_ACC_SEQ_BIAS_EN
    ,
    input  logic [CONF.prec-1:0]         bias
`endif
);

    localparam int W  = int'(CONF.prec);
    localparam int CW = cnt_width(BEATS);

    localparam logic [CW-1:0]  LAST_C        = CW'(BEATS - 1);
    localparam logic [CW-1:0]  ONE_C         = CW'(1'b1);
    // Where the first beat of a vector leads: a one-beat vector is done at once.
    localparam acc_seq_state_t FIRST_STATE_C = (BEATS == 1) ? S_OUT : S_ACC;
    localparam logic [CW-1:0]  FIRST_CNT_C   = (BEATS == 1) ? '0 : ONE_C;

    acc_seq_state_t      r_state;
    acc_seq_state_t      w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_nxt;
    logic [W-1:0]        r_acc;
    logic                r_ovf;
    logic                r_udf;
    logic                r_rnd;

    logic                w_accept;
    logic                w_first;
    logic [W-1:0]        w_fb;
    logic [IN:0][W-1:0]  w_lanes;
    logic [W-1:0]        w_sum;
    logic                w_p_ovf;
    logic                w_p_udf;
    logic                w_p_rnd;

    // A beat arriving while a result is presented starts the next vector.
    assign w_first  = (r_state == S_IDLE) || (r_state == S_OUT);
    assign w_accept = in_valid & in_ready;

    // While a result waits, a new beat may only enter if the result retires.
    always_comb begin
        case (r_state)
            S_IDLE:  in_ready = 1'b1;
            S_ACC:   in_ready = 1'b1;
            S_OUT:   in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    // Feedback lane: start value on the first beat, running sum afterwards.
    always_comb begin
        if (w_first) begin
`ifdef P_ACC_SEQ_BIAS_EN
            w_fb = bias;
`else
            w_fb = '0;
`endif
        end else begin
            w_fb = r_acc;
        end
    end

    assign w_lanes = {w_fb, in_data};

    p_acc #(
        .IN   (IN + 1),
        .CONF (CONF)
    ) u_p_acc (
        .in_data  (w_lanes),
        .out_data (w_sum),
        .out_ovf  (w_p_ovf),
        .out_udf  (w_p_udf),
        .out_rnd  (w_p_rnd)
    );

    // Next-state and beat counter; the counter wraps to 0 on the last beat.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = FIRST_STATE_C;
                    w_cnt_nxt   = FIRST_CNT_C;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = r_cnt;
                end
            end
            S_ACC: begin
                if (w_accept) begin
                    if (r_cnt == LAST_C) begin
                        w_state_nxt = S_OUT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = S_ACC;
                        w_cnt_nxt   = r_cnt + ONE_C;
                    end
                end else begin
                    w_state_nxt = S_ACC;
                    w_cnt_nxt   = r_cnt;
                end
            end
            S_OUT: begin
                if (w_accept) begin
                    w_state_nxt = FIRST_STATE_C;
                    w_cnt_nxt   = FIRST_CNT_C;
                end else if (out_ready) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = r_cnt;
                end else begin
                    w_state_nxt = S_OUT;
                    w_cnt_nxt   = r_cnt;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, running sum and sticky flags; flags restart on a vector's first beat.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
            r_rnd   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_acc <= w_sum;
                if (w_first) begin
                    r_ovf <= w_p_ovf;
                    r_udf <= w_p_udf;
                    r_rnd <= w_p_rnd;
                end else begin
                    r_ovf <= r_ovf | w_p_ovf;
                    r_udf <= r_udf | w_p_udf;
                    r_rnd <= r_rnd | w_p_rnd;
                end
            end else begin
                r_acc <= r_acc;
                r_ovf <= r_ovf;
                r_udf <= r_udf;
                r_rnd <= r_rnd;
            end
        end
    end

    assign out_valid = (r_state == S_OUT);
    assign out_data  = r_acc;
    assign out_ovf   = r_ovf;
    assign out_udf   = r_udf;
    assign out_rnd   = r_rnd;

endmodule

// File: tb/tb_p_acc_seq.sv
// ----------------------------------------------------------------------------
// tb_p_acc_seq
// Two instances: A (IN=4, BEATS=3) and B (IN=4, BEATS=1, bias=10 when
// P_ACC_SEQ_BIAS_EN is defined). Expected results are queued when the last
// beat of a vector is issued; a forked monitor compares at every falling edge
// where a result is presented and pops it when it is taken.
// ----------------------------------------------------------------------------
module tb_p_acc_seq;
    import p_acc_seq_pkg::*;

    typedef struct packed {
        logic [7:0] data;
        logic       ovf;
        logic       udf;
        logic       rnd;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset_;

    logic            a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [3:0][7:0] a_in_data;
    logic [7:0]      a_out_data;
    logic            a_out_ovf, a_out_udf, a_out_rnd;

    logic            b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [3:0][7:0] b_in_data;
    logic [7:0]      b_out_data;
    logic            b_out_ovf, b_out_udf, b_out_rnd;
`ifdef P_ACC_SEQ_BIAS_EN
    logic [7:0]      b_bias = 8'd10;
    logic [7:0]      a_bias = 8'd0;
`endif

    exp_t qa[$];
    exp_t qb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic ov;

    always #5 clk = ~clk;

    p_acc_seq #(.IN(4), .BEATS(3), .CONF(`DEF_DCONF)) u_dut_a (
        .clk(clk), .reset_(reset_),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_ovf(a_out_ovf), .out_udf(a_out_udf), .out_rnd(a_out_rnd)
`ifdef P_ACC_SEQ_BIAS_EN
        , .bias(a_bias)
`endif
    );

    p_acc_seq #(.IN(4), .BEATS(1), .CONF(`DEF_DCONF)) u_dut_b (
        .clk(clk), .reset_(reset_),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_ovf(b_out_ovf), .out_udf(b_out_udf), .out_rnd(b_out_rnd)
`ifdef P_ACC_SEQ_BIAS_EN
        , .bias(b_bias)
`endif
    );

    function automatic exp_t mk(input logic [7:0] d, input logic o);
        return '{data: d, ovf: o, udf: 1'b0, rnd: 1'b0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (qa.size() != 0) begin
                if (a_out_valid) begin
                    chk("a_result", 32'({a_out_data, a_out_ovf, a_out_udf, a_out_rnd}), 32'(qa[0]));
                    if (a_out_ready) begin
                        void'(qa.pop_front());
                    end else begin
                        chk("a_ready_while_stalled", 32'(a_in_ready), 32'd0);
                    end
                end
            end else if (a_out_valid) begin
                chk("a_spurious_valid", 32'(a_out_valid), 32'd0);
            end
            if (qb.size() != 0) begin
                if (b_out_valid) begin
                    chk("b_result", 32'({b_out_data, b_out_ovf, b_out_udf, b_out_rnd}), 32'(qb[0]));
                    if (b_out_ready) begin
                        void'(qb.pop_front());
                    end
                end
            end else if (b_out_valid) begin
                chk("b_spurious_valid", 32'(b_out_valid), 32'd0);
            end
        end
    endtask

    task automatic send_a(input logic [31:0] d, output logic ov_at_accept);
        int   n;
        logic acc;
        n            = 0;
        acc          = 1'b0;
        ov_at_accept = 1'b0;
        a_in_valid   = 1'b1;
        a_in_data    = d;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc          = a_in_ready;
            ov_at_accept = a_out_valid;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("a_accept_timeout", 32'(acc), 32'd1);
        a_in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (qa.size() == 0 && qb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        if (qa.size() != 0 || qb.size() != 0)
            chk("drain_timeout", 32'(qa.size() + qb.size()), 32'd0);
    endtask

    initial begin
        reset_      = 1'b0;
        a_in_valid  = 1'b0;
        a_in_data   = '0;
        a_out_ready = 1'b1;
        b_in_valid  = 1'b0;
        b_in_data   = '0;
        b_out_ready = 1'b1;
        fork
            monitor_loop();
        join_none

        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_a_in_ready",  32'(a_in_ready),  32'd1);
        chk("rst_a_out",       32'({a_out_data, a_out_ovf, a_out_udf, a_out_rnd}), 32'd0);
        chk("rst_b_out_valid", 32'(b_out_valid), 32'd0);
        chk("rst_b_in_ready",  32'(b_in_ready),  32'd1);
        @(negedge clk);
        reset_ = 1'b1;
        @(posedge clk);
        #1;

        // 1: back-to-back beats, 1+..+12 = 78, valid one cycle after beat 3
        send_a({8'd4, 8'd3, 8'd2, 8'd1}, ov);
        send_a({8'd8, 8'd7, 8'd6, 8'd5}, ov);
        qa.push_back(mk(8'd78, 1'b0));
        send_a({8'd12, 8'd11, 8'd10, 8'd9}, ov);
        @(negedge clk);
        chk("t1_latency", 32'(a_out_valid), 32'd1);
        @(posedge clk);
        #1;
        drain();

        // 2: gaps of 2 cycles, result stalled 5 cycles
        a_out_ready = 1'b0;
        send_a({8'd4, 8'd3, 8'd2, 8'd1}, ov);
        repeat (2) begin @(posedge clk); #1; end
        send_a({8'd8, 8'd7, 8'd6, 8'd5}, ov);
        repeat (2) begin @(posedge clk); #1; end
        qa.push_back(mk(8'd78, 1'b0));
        send_a({8'd12, 8'd11, 8'd10, 8'd9}, ov);
        repeat (5) begin @(posedge clk); #1; end
        a_out_ready = 1'b1;
        drain();

        // 3: 4*127 clips to 127, 127-400 clips to -128, -128+4 = -124 (0x84), ovf sticky
        send_a({4{8'd127}}, ov);
        send_a({4{8'h9C}}, ov);
        qa.push_back(mk(8'h84, 1'b1));
        send_a({4{8'd1}}, ov);
        // 4: two more vectors streamed with no bubble; flags restart per vector
        send_a({8'd4, 8'd3, 8'd2, 8'd1}, ov);
        chk("t4_first_beat_in_out_a", 32'(ov), 32'd1);
        send_a({8'd8, 8'd7, 8'd6, 8'd5}, ov);
        qa.push_back(mk(8'd78, 1'b0));
        send_a({8'd12, 8'd11, 8'd10, 8'd9}, ov);
        send_a(32'd0, ov);
        chk("t4_first_beat_in_out_b", 32'(ov), 32'd1);
        send_a(32'd0, ov);
        qa.push_back(mk(8'd0, 1'b0));
        send_a(32'd0, ov);
        drain();

        // 5: reset after beat 2 discards the partial sum (36)
        send_a({8'd4, 8'd3, 8'd2, 8'd1}, ov);
        send_a({8'd8, 8'd7, 8'd6, 8'd5}, ov);
        reset_ = 1'b0;
        #1;
        chk("t5_rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("t5_rst_in_ready",  32'(a_in_ready),  32'd1);
        chk("t5_rst_out_data",  32'(a_out_data),  32'd0);
        @(negedge clk);
        reset_ = 1'b1;
        @(posedge clk);
        #1;
        send_a({4{8'd1}}, ov);
        send_a({4{8'd1}}, ov);
        qa.push_back(mk(8'd12, 1'b0));
        send_a({4{8'd1}}, ov);
        drain();

        // 6: one-beat vectors on B, streamed back-to-back
        b_in_valid = 1'b1;
        b_in_data  = {4{8'd1}};
`ifdef P_ACC_SEQ_BIAS_EN
        qb.push_back(mk(8'd14, 1'b0));
`else
        qb.push_back(mk(8'd4, 1'b0));
`endif
        @(negedge clk);
        chk("t6_b_ready_idle", 32'(b_in_ready), 32'd1);
        @(posedge clk);
        #1;
        b_in_data = {4{8'd2}};
`ifdef P_ACC_SEQ_BIAS_EN
        qb.push_back(mk(8'd18, 1'b0));
`else
        qb.push_back(mk(8'd8, 1'b0));
`endif
        @(negedge clk);
        chk("t6_b_latency",   32'(b_out_valid), 32'd1);
        chk("t6_b_ready_out", 32'(b_in_ready),  32'd1);
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
